gsu_icache: RTL and testbench

GSU_ICACHE -- requirements
Module: gsu_icache

---
 rtl/gsu_pkg.sv | 7 +
 rtl/gsu_cache.sv | 18 +
 rtl/gsu_icache.sv | 125 ++++++++++++
 tb/tb_gsu_icache.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/gsu_pkg.sv
// gsu_pkg: shared state encoding, default geometry and window base for the GSU instruction cache
package gsu_pkg;
    typedef enum logic [1:0] {IDLE, LOOKUP, FILL, BYPASS} icache_state_t;
    localparam int DEF_LINES = 32;
    localparam int DEF_LINE_BYTES = 16;
    localparam logic [15:0] CACHE_WIN_BASE = 16'h3100;
endpackage

// File: rtl/gsu_cache.sv
// gsu_cache: byte-wide dual-port cache RAM, port A synchronous write, port B synchronous read
module gsu_cache #(
    parameter int DEPTH = 512,
    localparam int AWR = $clog2(DEPTH)
) (
    input  logic           clk,
    input  logic           we_a,
    input  logic [AWR-1:0] addr_a,
    input  logic [7:0]     wdata_a,
    input  logic [AWR-1:0] addr_b,
    output logic [7:0]     rdata_b
);
    logic [7:0] mem [DEPTH];
    always_ff @(posedge clk) begin
        if (we_a) mem[addr_a] <= wdata_a;
        rdata_b <= mem[addr_b];
    end
endmodule

// File: rtl/gsu_icache.sv
// gsu_icache: GSU opcode fetch cache with line fill and out-of-window bypass
// SNES cache-window write port is enabled by defining GSU_ICACHE_SNES_WR_EN
module gsu_icache
    import gsu_pkg::*;
#(
    parameter int LINES = DEF_LINES,
    parameter int LINE_BYTES = DEF_LINE_BYTES,
    parameter int AW = 16,
    localparam int OW = $clog2(LINES * LINE_BYTES)
) (
    input  logic          clkin,
    input  logic          RESET,
    input  logic          fetch_req,
    input  logic [AW-1:0] fetch_addr,
    output logic          fetch_ack,
    output logic [7:0]    fetch_data,
    input  logic [AW-1:0] cbr,
    input  logic          flush,
    output logic          mem_req,
    output logic [AW-1:0] mem_addr,
    input  logic          mem_ack,
    input  logic [7:0]    mem_data,
    input  logic          snes_we,
    input  logic [OW-1:0] snes_waddr,
    input  logic [7:0]    snes_wdata,
    output logic          busy
);
    localparam int BW = $clog2(LINE_BYTES);
    localparam int LW = $clog2(LINES);

    icache_state_t state;
    logic [LINES-1:0] valid;
    logic [AW-1:0] addr_q, cbr_al, off;
    logic [LW-1:0] line, line_q;
    logic [BW-1:0] k;
    logic [7:0] req_byte, rdata, a_data;
    logic [OW-1:0] rd_addr, a_addr;
    logic flush_pend, in_win, fill_wr, snes_wr, a_we;

    assign cbr_al = cbr & ~AW'(LINE_BYTES - 1);
    assign off = addr_q - cbr_al;
    assign in_win = (off >> OW) == '0;
    assign line = off[OW-1:BW];
    // Read port follows the incoming address in IDLE so the byte is ready in LOOKUP
    assign rd_addr = OW'((state == IDLE ? fetch_addr : addr_q) - cbr_al);
    assign busy = state != IDLE;
    assign fill_wr = (state == FILL) && mem_ack;
`ifdef GSU_ICACHE_SNES_WR_EN
    assign snes_wr = snes_we && (state != FILL);
`else
    assign snes_wr = 1'b0;
`endif
    assign a_we = fill_wr || snes_wr;
    assign a_addr = fill_wr ? {line_q, k} : snes_waddr;
    assign a_data = fill_wr ? mem_data : snes_wdata;

    gsu_cache #(.DEPTH(LINES * LINE_BYTES)) u_ram (
        .clk(clkin), .we_a(a_we), .addr_a(a_addr), .wdata_a(a_data),
        .addr_b(rd_addr), .rdata_b(rdata)
    );

    always_ff @(posedge clkin) begin
        if (RESET) begin
            state <= IDLE;
            valid <= '0;
            fetch_ack <= 1'b0;
            mem_req <= 1'b0;
            k <= '0;
            flush_pend <= 1'b0;
        end else begin
            fetch_ack <= 1'b0;
            if (flush) valid <= '0;
            if (snes_wr && &snes_waddr[BW-1:0]) valid[snes_waddr[OW-1:BW]] <= 1'b1;
            case (state)
                IDLE: if (fetch_req && !fetch_ack) begin
                    addr_q <= fetch_addr;
                    state <= LOOKUP;
                end
                LOOKUP: if (!in_win) begin
                    mem_req <= 1'b1;
                    mem_addr <= addr_q;
                    state <= BYPASS;
                end else if (valid[line]) begin
                    fetch_ack <= 1'b1;
                    fetch_data <= rdata;
                    state <= IDLE;
                end else begin
                    mem_req <= 1'b1;
                    mem_addr <= {addr_q[AW-1:BW], {BW{1'b0}}};
                    k <= '0;
                    line_q <= line;
                    flush_pend <= 1'b0;
                    state <= FILL;
                end
                FILL: begin
                    if (flush) flush_pend <= 1'b1;
                    if (mem_ack) begin
                        if (k == addr_q[BW-1:0]) req_byte <= mem_data;
                        mem_addr <= mem_addr + 1'b1;
                        k <= k + 1'b1;
                        // A flush aborts only once the outstanding byte has landed
                        if (flush || flush_pend) begin
                            mem_req <= 1'b0;
                            k <= '0;
                            state <= LOOKUP;
                        end else if (&k) begin
                            valid[line_q] <= 1'b1;
                            fetch_ack <= 1'b1;
                            fetch_data <= (k == addr_q[BW-1:0]) ? mem_data : req_byte;
                            mem_req <= 1'b0;
                            state <= IDLE;
                        end
                    end
                end
                BYPASS: if (mem_ack) begin
                    mem_req <= 1'b0;
                    fetch_ack <= 1'b1;
                    fetch_data <= mem_data;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_gsu_icache.sv
// tb_gsu_icache: scoreboard bench for gsu_icache, default geometry plus a 64x8 instance
module tb_gsu_icache;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, flush, flush_r, flush_m, snes_we;
    logic [15:0] cbr;
    logic [1:0] fetch_req, fetch_ack, mem_req, mem_ack, busy;
    logic [15:0] fetch_addr [2];
    logic [15:0] mem_addr [2];
    logic [7:0] fetch_data [2];
    logic [7:0] mem_data [2];
    logic [8:0] snes_waddr;
    logic [7:0] snes_wdata;
    int sel = 0, flush_at = -1, nack = 0, lat;
    int errors = 0, checks = 0;
    logic [7:0] exp_f [$];
    logic [15:0] exp_m [$];

    assign flush = flush_r | flush_m;

    gsu_icache u0 (
        .clkin(clk), .RESET(rst), .fetch_req(fetch_req[0]), .fetch_addr(fetch_addr[0]),
        .fetch_ack(fetch_ack[0]), .fetch_data(fetch_data[0]), .cbr(cbr), .flush(flush),
        .mem_req(mem_req[0]), .mem_addr(mem_addr[0]), .mem_ack(mem_ack[0]), .mem_data(mem_data[0]),
        .snes_we(snes_we), .snes_waddr(snes_waddr), .snes_wdata(snes_wdata), .busy(busy[0])
    );

    gsu_icache #(.LINES(64), .LINE_BYTES(8)) u1 (
        .clkin(clk), .RESET(rst), .fetch_req(fetch_req[1]), .fetch_addr(fetch_addr[1]),
        .fetch_ack(fetch_ack[1]), .fetch_data(fetch_data[1]), .cbr(cbr), .flush(flush),
        .mem_req(mem_req[1]), .mem_addr(mem_addr[1]), .mem_ack(mem_ack[1]), .mem_data(mem_data[1]),
        .snes_we(1'b0), .snes_waddr(snes_waddr), .snes_wdata(snes_wdata), .busy(busy[1])
    );

    function automatic logic [7:0] md(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'hA5;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic push_mem(input logic [15:0] base, input int n);
        for (int i = 0; i < n; i++) exp_m.push_back(16'(base + i));
    endtask

    task automatic fetch(input int c, input logic [15:0] a, input logic [7:0] e, output int l);
        @(negedge clk);
        exp_f.push_back(e);
        fetch_addr[c] = a;
        fetch_req[c] = 1'b1;
        l = 0;
        do begin
            @(negedge clk);
            l++;
        end while (!fetch_ack[c] && l < 300);
        fetch_req[c] = 1'b0;
        if (!fetch_ack[c]) chk("fetch_timeout", fetch_ack[c], 1'b1);
    endtask

    // Backing memory: acks each request one cycle after it appears and checks its address
    initial begin
        mem_ack = '0;
        mem_data[0] = '0;
        mem_data[1] = '0;
        flush_r = 1'b0;
        forever begin
            @(negedge clk);
            flush_r = 1'b0;
            if (mem_ack != '0) mem_ack = '0;
            else if (mem_req[sel]) begin
                if (exp_m.size() == 0) chk("mem_unexpected", mem_req[sel], 1'b0);
                else chk("mem_addr", mem_addr[sel], exp_m.pop_front());
                mem_data[sel] = md(mem_addr[sel]);
                mem_ack[sel] = 1'b1;
                nack++;
                if (nack == flush_at) flush_r = 1'b1;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            for (int c = 0; c < 2; c++) if (fetch_ack[c]) begin
                if (exp_f.size() == 0) chk("ack_unexpected", fetch_ack[c], 1'b0);
                else begin
                    chk("ack_channel", c, sel);
                    chk("fetch_data", fetch_data[c], exp_f.pop_front());
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        fetch_req = '0;
        fetch_addr[0] = '0;
        fetch_addr[1] = '0;
        flush_m = 1'b0;
        snes_we = 1'b0;
        snes_waddr = '0;
        snes_wdata = '0;
        cbr = 16'h8000;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_fetch_ack", fetch_ack, 2'b00);
        chk("rst_mem_req", mem_req, 2'b00);
        chk("rst_busy", busy, 2'b00);
        chk("rst_valid0", u0.valid, 0);
        chk("rst_valid1", u1.valid, 0);

        push_mem(16'h8000, 16);
        fetch(0, 16'h8005, md(16'h8005), lat);
        chk("fill_valid", u0.valid, 32'h1);

        cbr = 16'h8007;
        fetch(0, 16'h800A, md(16'h800A), lat);
        chk("hit_latency", lat, 2);
        cbr = 16'h8000;

        push_mem(16'h7FFF, 1);
        fetch(0, 16'h7FFF, md(16'h7FFF), lat);
        chk("bypass_valid", u0.valid, 32'h1);

        flush_at = nack + 3;
        push_mem(16'h8010, 3);
        push_mem(16'h8010, 16);
        fetch(0, 16'h8013, md(16'h8013), lat);
        chk("flush_fill_valid", u0.valid, 32'h2);

        @(negedge clk);
        exp_f.push_back(md(16'h8014));
        fetch_addr[0] = 16'h8014;
        fetch_req[0] = 1'b1;
        @(negedge clk);
        flush_m = 1'b1;
        @(negedge clk);
        flush_m = 1'b0;
        fetch_req[0] = 1'b0;
        chk("hit_under_flush", fetch_ack[0], 1'b1);
        chk("flush_clears", u0.valid, 0);

        push_mem(16'h8000, 16);
        fetch_addr[0] = 16'h8000;
        fetch_req[0] = 1'b1;
        repeat (6) @(negedge clk);
        rst = 1'b1;
        fetch_req[0] = 1'b0;
        @(negedge clk);
        chk("midfill_rst_mem_req", mem_req[0], 1'b0);
        chk("midfill_rst_busy", busy[0], 1'b0);
        rst = 1'b0;
        exp_m.delete();
        repeat (3) @(negedge clk);
        chk("midfill_rst_valid", u0.valid, 0);

        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            snes_we = 1'b1;
            snes_waddr = 9'(i);
            snes_wdata = 8'(8'h40 + i);
        end
        @(negedge clk);
        snes_we = 1'b0;
`ifdef GSU_ICACHE_SNES_WR_EN
        chk("snes_valid", u0.valid, 32'h1);
        fetch(0, 16'h8003, 8'h43, lat);
        chk("snes_hit_latency", lat, 2);
`else
        chk("snes_ignored_valid", u0.valid, 0);
        push_mem(16'h8000, 16);
        fetch(0, 16'h8003, md(16'h8003), lat);
`endif

        sel = 1;
        push_mem(16'h81F8, 8);
        fetch(1, 16'h81F8, md(16'h81F8), lat);
        chk("l64_valid63", u1.valid, 64'h8000_0000_0000_0000);
        push_mem(16'h8200, 1);
        fetch(1, 16'h8200, md(16'h8200), lat);
        chk("l64_bypass_valid", u1.valid, 64'h8000_0000_0000_0000);

        repeat (5) @(negedge clk);
        chk("exp_f_drained", exp_f.size(), 0);
        chk("exp_m_drained", exp_m.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
